// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width, multiplier FSM states and
// radix-4 Booth digit flag encodings.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // zero: contribute nothing; two: use 2M instead of M; neg: subtract
  typedef struct packed {
    logic zero;
    logic neg;
    logic two;
  } booth_flags_t;

  localparam booth_flags_t DIG_ZERO = 3'b100;
  localparam booth_flags_t DIG_POS1 = 3'b000;
  localparam booth_flags_t DIG_POS2 = 3'b001;
  localparam booth_flags_t DIG_NEG1 = 3'b010;
  localparam booth_flags_t DIG_NEG2 = 3'b011;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps {q1, q0, q-1} onto zero/neg/two selection flags.
module booth_recode
  import alu_pkg::*;
(
  input  logic [2:0]   i_digit,
  output booth_flags_t o_flags
);

  always_comb begin
    o_flags = DIG_ZERO;
    unique case (i_digit)
      3'b001, 3'b010: o_flags = DIG_POS1;
      3'b011:         o_flags = DIG_POS2;
      3'b100:         o_flags = DIG_NEG2;
      3'b101, 3'b110: o_flags = DIG_NEG1;
      default:        o_flags = DIG_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed WIDTH x WIDTH radix-4 Booth multiplier, one digit per clock,
// with start/busy/done handshake and a product register held between operations.
module booth_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned ITER = WIDTH / 2;
  localparam int unsigned UW   = WIDTH + 2;
  localparam int unsigned AW   = 2 * WIDTH + 3;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_m;
  logic [AW-1:0]        r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  booth_flags_t         w_flags;
  logic [UW-1:0]        w_mag;
  logic [UW-1:0]        w_addend;
  logic [UW-1:0]        w_upper;
  logic [AW-1:0]        w_acc_sum;
  logic [AW-1:0]        w_acc_next;
  logic                 w_last;
  logic                 w_accept;

  booth_recode u_recode (
    .i_digit (r_acc[2:0]),
    .o_flags (w_flags)
  );

  // Upper field is WIDTH+2 bits wide so that +/-2M of the most negative M fits
  always_comb begin
    w_mag = '0;
    if (!w_flags.zero) begin
      if (w_flags.two) w_mag = {r_m[WIDTH-1], r_m, 1'b0};
      else             w_mag = {{2{r_m[WIDTH-1]}}, r_m};
    end
    w_addend   = w_flags.neg ? (~w_mag + UW'(1)) : w_mag;
    w_upper    = r_acc[AW-1:WIDTH+1] + w_addend;
    w_acc_sum  = {w_upper, r_acc[WIDTH:0]};
    w_acc_next = {{2{w_acc_sum[AW-1]}}, w_acc_sum[AW-1:2]};
  end

  assign w_last   = (r_cnt == CW'(ITER - 1));
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: w_next = start ? RUN : IDLE;
      RUN:        if (w_last) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_m   <= multiplicand;
        r_acc <= {{UW{1'b0}}, multiplier, 1'b0};
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) r_product <= w_acc_next[2*WIDTH:1];
      end
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases plus randomized
// operands compared against a signed 64-bit arithmetic reference.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] mc;
  logic [31:0] mp;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] last_prod = '0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (mc),
    .multiplier   (mp),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge where done is high.
  task automatic do_mul(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input int poke_at);
    int          n = 0;
    int          bc = 0;
    logic        hold_ok = 1'b1;
    logic [63:0] exp;
    exp   = ref_mul(m, q);
    start = 1'b1;
    mc    = m;
    mp    = q;
    @(negedge clk);
    start = 1'b0;
    mc    = $urandom;
    mp    = $urandom;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      if (product !== last_prod) hold_ok = 1'b0;
      start = (n == poke_at);
      if (n == poke_at) begin
        mc = 32'd100;
        mp = 32'd100;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'd16);
    check({tag, " busy_cycles"}, 64'(bc), 64'd16);
    check({tag, " hold"}, 64'(hold_ok), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " product"}, product, exp);
    last_prod = exp;
  endtask

  initial begin
    int          cnt_done;
    int          cnt_busy;
    logic        still;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b1;
    start = 1'b0;
    mc    = '0;
    mp    = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    reset = 1'b0;
    still = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) still = 1'b0;
    end
    check("idle stable", 64'(still), 64'd1);

    do_mul("basic", 32'd7, 32'hFFFF_FFFD, -1);
    check("basic const", product, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check("basic done_pulse", 64'(done), 64'd0);

    do_mul("minmin", 32'h8000_0000, 32'h8000_0000, -1);
    check("minmin const", product, 64'h4000_0000_0000_0000);
    do_mul("neg1neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    check("neg1neg1 const", product, 64'h0000_0000_0000_0001);
    do_mul("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
    check("maxmax const", product, 64'h3FFF_FFFF_0000_0001);
    @(negedge clk);
    check("maxmax done_pulse", 64'(done), 64'd0);

    do_mul("ignore_start", 32'd5, 32'd6, 5);
    check("ignore_start const", product, 64'd30);
    cnt_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) cnt_done++;
    end
    check("ignore_start no_second_done", 64'(cnt_done), 64'd0);
    check("ignore_start product_kept", product, 64'd30);

    start = 1'b1;
    mc    = 32'h1234;
    mp    = 32'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("midrun busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset busy", 64'(busy), 64'd0);
    check("async_reset done", 64'(done), 64'd0);
    check("async_reset product", product, 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    last_prod = '0;
    cnt_done  = 0;
    cnt_busy  = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) cnt_done++;
      if (busy === 1'b1) cnt_busy++;
    end
    check("after_reset no_done", 64'(cnt_done), 64'd0);
    check("after_reset no_busy", 64'(cnt_busy), 64'd0);
    do_mul("after_reset", 32'd3, 32'd4, -1);
    check("after_reset const", product, 64'd12);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      a = pick_operand();
      b = pick_operand();
      do_mul("rand", a, b, -1);
      if ($urandom_range(1) == 0) begin
        @(negedge clk);
        check("rand done_pulse", 64'(done), 64'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential signed 32x32 multiplier using radix-4 Booth recoding, one recoded digit per clock.
- Multiplication is the inverse operation of the existing combinational divider. This block feeds the ALU MUL path.
- The 64-bit product loads HI (product[63:32]) and LO (product[31:0]), the same split the divider uses for remainder/quotient.
- Start/busy/done handshake lets the control unit stall for a fixed 16-cycle latency.

Parameters:
- WIDTH, 32, operand width. Must be even. Product is 2*WIDTH bits.
- ITER, WIDTH/2, number of Booth iterations. Derived; not for override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled on clk rising edge
- multiplicand  input  WIDTH  signed operand M, captured when start is accepted
- multiplier  input  WIDTH  signed operand Q, captured when start is accepted
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse: product valid
- product  output  2*WIDTH  signed result {HI, LO}; held until the next accepted start

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE, busy = 0, done = 0, product = 0, iteration count = 0.
  - The in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start = 1: latch M; load accumulator = {(WIDTH+2) zeros, Q, 1'b0} (Q with the q(-1) bit = 0); count = 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per edge:
  - Digit bits d = acc[2:0], i.e. {q1, q0, q-1}.
  - Digit mapping: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Add the selected value, sign-extended to WIDTH+2 bits, into the upper WIDTH+2 bits of the accumulator.
  - Then arithmetic-shift the whole accumulator right by 2.
  - count increments. On the edge where count = ITER-1 completes, write product = acc[2*WIDTH:1] (post-shift) and go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. start is accepted in DONE exactly as in IDLE (back-to-back operation, no dead cycle).
- Latency: start sampled at edge N -> done high in the cycle after edge N+ITER (edge N+16 for WIDTH = 32).
- product changes only on that same edge. It is never updated mid-operation.
- busy = 1 exactly in RUN (ITER cycles). start during RUN is ignored; operands and the in-flight result are unaffected.
- Width rules:
  - Upper accumulator field is WIDTH+2 bits, so ±2M never overflows, including M = -2^(WIDTH-1).
  - All additions are two's complement; -M and -2M are formed by invert-plus-one within WIDTH+2 bits.
- Operands are used only as captured at the start edge. Input changes afterwards have no effect.

Decomposition:
- Shared package (alu_pkg): WIDTH default constant, state enum {IDLE, RUN, DONE}, Booth digit encoding constants (zero/neg/two flags).
- One sub-module: booth_recode.
  - Combinational; 3-bit digit in -> {zero, neg, two} out.
  - Instantiated once; the datapath selects 0/M/2M and conditionally negates based on these flags.
- Top contains the FSM, counter, accumulator and product register.

Test Plan:
- Reset then idle: reset high for 2 cycles, start = 0 -> busy = 0, done = 0, product = 0; no change for 20 cycles.
- Basic signed multiply: M = 7, Q = 0xFFFF_FFFD (-3), start pulsed at edge N -> busy high for 16 cycles; done pulse at edge N+16; product = 0xFFFF_FFFF_FFFF_FFEB.
- Corner operands, back-to-back:
  - M = Q = 0x8000_0000 -> product = 0x4000_0000_0000_0000.
  - Then start asserted in the DONE cycle with M = Q = 0xFFFF_FFFF -> product = 0x0000_0000_0000_0001 after another 16 cycles.
  - Then M = Q = 0x7FFF_FFFF -> product = 0x3FFF_FFFF_0000_0001.
- Start during busy ignored:
  - M = 5, Q = 6 started; at cycle 5 of RUN pulse start with M = 100, Q = 100.
  - Required: single done at N+16, product = 30, no second done.
- Reset mid-operation:
  - Start M = 0x1234, Q = 0x10; assert reset at RUN cycle 8.
  - Required: busy = 0, done = 0, product = 0 immediately (asynchronous), no done afterward.
  - Fresh start M = 3, Q = 4 -> product = 12 after 16 cycles.
- Randomized cross-check: 1000 random signed pairs, including 0, ±1, min and max values. Compare against a 64-bit signed reference product; check done/busy timing on every operation.
